led_bar_monitor: RTL and testbench



---
 rtl/led_bar_monitor_pkg.sv | 26 ++
 rtl/led_bar_monitor_if.sv | 32 +++
 rtl/led_thermo_decode.sv | 22 ++
 rtl/led_bar_monitor.sv | 177 +++++++++++++++++
 tb/tb_led_bar_monitor.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/led_bar_monitor_pkg.sv
// rtl/led_bar_monitor_pkg.sv - shared types and constants for the LED bar monitor
// Contents: monitor state enum, direction codes, error cause codes, default geometry.
package led_bar_monitor_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_LVL_W = 5;
    localparam int DEF_QUIET = 4;
    localparam int DEF_SEQ_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UP,
        ST_DOWN,
        ST_ZERO,
        ST_RESYNC
    } state_t;

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_THERMO = 2'b01;
    localparam logic [1:0] ERR_JUMP   = 2'b10;

endpackage

// File: rtl/led_bar_monitor_if.sv
// rtl/led_bar_monitor_if.sv - LED bus sample input and monitor status outputs
// master: drives led_in, observes status. slave: the monitor (samples led_in,
// drives level, dir, peak_pulse, valley_pulse, turn_level, seq_done, seq_count,
// error, err_code).
interface led_bar_monitor_if #(
    parameter int WIDTH = 16,
    parameter int LVL_W = 5,
    parameter int SEQ_W = 8
);
    logic [WIDTH-1:0] led_in;
    logic [LVL_W-1:0] level;
    logic [1:0]       dir;
    logic             peak_pulse;
    logic             valley_pulse;
    logic [LVL_W-1:0] turn_level;
    logic             seq_done;
    logic [SEQ_W-1:0] seq_count;
    logic             error;
    logic [1:0]       err_code;

    modport master (
        output led_in,
        input  level, dir, peak_pulse, valley_pulse, turn_level,
        input  seq_done, seq_count, error, err_code
    );

    modport slave (
        input  led_in,
        output level, dir, peak_pulse, valley_pulse, turn_level,
        output seq_done, seq_count, error, err_code
    );
endinterface

// File: rtl/led_thermo_decode.sv
// rtl/led_thermo_decode.sv - combinational thermometer-code checker and level decoder
// Ports: led_in (bar sample) -> valid (contiguous ones from bit 0), n (count of ones).
module led_thermo_decode
    import led_bar_monitor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LVL_W = DEF_LVL_W
) (
    input  logic [WIDTH-1:0] led_in,
    output logic             valid,
    output logic [LVL_W-1:0] n
);
    always_comb begin
        // A thermometer code plus one is a power of two (or wraps to zero for
        // all ones), so it shares no set bit with the original value.
        valid = ((led_in & (led_in + WIDTH'(1))) == '0);
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + LVL_W'(led_in[i]);
        end
    end
endmodule

// File: rtl/led_bar_monitor.sv
// rtl/led_bar_monitor.sv - LED bar level tracker with peak/valley, sequence-end and error reporting
// Ports: clk, rst (async active-high); bus (slave modport): led_in in; level, dir,
// peak_pulse, valley_pulse, turn_level, seq_done, seq_count, error, err_code out.
module led_bar_monitor
    import led_bar_monitor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LVL_W = DEF_LVL_W,
    parameter int QUIET = DEF_QUIET,
    parameter int SEQ_W = DEF_SEQ_W
) (
    input  logic               clk,
    input  logic               rst,
    led_bar_monitor_if.slave   bus
);
    localparam int QW = $clog2(QUIET + 1);

    logic             valid;
    logic [LVL_W-1:0] n;

    led_thermo_decode #(.WIDTH(WIDTH), .LVL_W(LVL_W)) u_decode (
        .led_in (bus.led_in),
        .valid  (valid),
        .n      (n)
    );

    state_t           state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;     // also serves as the previous level p
    logic [1:0]       dir_q, dir_d;
    logic             peak_q, peak_d;
    logic             valley_q, valley_d;
    logic [LVL_W-1:0] turn_q, turn_d;
    logic             done_q, done_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             error_q, error_d;
    logic [1:0]       code_q, code_d;
    logic [QW-1:0]    quiet_q, quiet_d;

    logic is_hold, is_up, is_down, is_jump;

    always_comb begin
        is_hold = (n == level_q);
        is_up   = (n == level_q + LVL_W'(1));
        is_down = (level_q != '0) && (n == level_q - LVL_W'(1));
        is_jump = valid && !is_hold && !is_up && !is_down;
    end

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        dir_d    = DIR_HOLD;
        peak_d   = 1'b0;
        valley_d = 1'b0;
        turn_d   = turn_q;
        done_d   = 1'b0;
        seq_d    = seq_q;
        error_d  = error_q;
        code_d   = code_q;
        quiet_d  = quiet_q;

        if (valid) begin
            level_d = n;
        end

        if (!valid || is_jump) begin
            state_d = ST_RESYNC;
            error_d = 1'b1;
            quiet_d = '0;
            if (!error_q) begin
                code_d = valid ? ERR_JUMP : ERR_THERMO;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (is_up) begin
                        state_d = ST_UP;
                        dir_d   = DIR_UP;
                    end
                end
                ST_UP: begin
                    if (is_up) begin
                        dir_d = DIR_UP;
                    end else if (is_down) begin
                        peak_d = 1'b1;
                        turn_d = level_q;
                        dir_d  = DIR_DOWN;
                        // A peak at level 1 lands straight on zero.
                        if (n == '0) begin
                            state_d = ST_ZERO;
                            quiet_d = QW'(1);
                        end else begin
                            state_d = ST_DOWN;
                        end
                    end
                end
                ST_DOWN: begin
                    if (is_down) begin
                        dir_d = DIR_DOWN;
                        if (n == '0) begin
                            state_d = ST_ZERO;
                            quiet_d = QW'(1);
                        end
                    end else if (is_up) begin
                        valley_d = 1'b1;
                        turn_d   = level_q;
                        dir_d    = DIR_UP;
                        state_d  = ST_UP;
                    end
                end
                ST_ZERO: begin
                    if (is_hold) begin
                        if (int'(quiet_q) + 1 >= QUIET) begin
                            done_d  = 1'b1;
                            quiet_d = '0;
                            state_d = ST_IDLE;
                            if (seq_q != '1) begin
                                seq_d = seq_q + SEQ_W'(1);
                            end
                        end else begin
                            quiet_d = quiet_q + QW'(1);
                        end
                    end else if (is_up) begin
                        valley_d = 1'b1;
                        turn_d   = '0;
                        dir_d    = DIR_UP;
                        quiet_d  = '0;
                        state_d  = ST_UP;
                    end
                end
                ST_RESYNC: begin
                    if (n == '0) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            level_q  <= '0;
            dir_q    <= DIR_HOLD;
            peak_q   <= 1'b0;
            valley_q <= 1'b0;
            turn_q   <= '0;
            done_q   <= 1'b0;
            seq_q    <= '0;
            error_q  <= 1'b0;
            code_q   <= ERR_NONE;
            quiet_q  <= '0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            dir_q    <= dir_d;
            peak_q   <= peak_d;
            valley_q <= valley_d;
            turn_q   <= turn_d;
            done_q   <= done_d;
            seq_q    <= seq_d;
            error_q  <= error_d;
            code_q   <= code_d;
            quiet_q  <= quiet_d;
        end
    end

    assign bus.level        = level_q;
    assign bus.dir          = dir_q;
    assign bus.peak_pulse   = peak_q;
    assign bus.valley_pulse = valley_q;
    assign bus.turn_level   = turn_q;
    assign bus.seq_done     = done_q;
    assign bus.seq_count    = seq_q;
    assign bus.error        = error_q;
    assign bus.err_code     = code_q;
endmodule

// File: tb/tb_led_bar_monitor.sv
// tb/tb_led_bar_monitor.sv - self-checking bench for led_bar_monitor
module tb_led_bar_monitor;
    localparam int WIDTH = 16;
    localparam int LVL_W = 5;
    localparam int QUIET = 4;
    localparam int SEQ_W = 8;

    logic clk;
    logic rst;

    led_bar_monitor_if #(.WIDTH(WIDTH), .LVL_W(LVL_W), .SEQ_W(SEQ_W)) bus ();

    led_bar_monitor #(.WIDTH(WIDTH), .LVL_W(LVL_W), .QUIET(QUIET), .SEQ_W(SEQ_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: level, trend (+1 rising, -1 falling, 0 idle), length of
    // the current zero run inside a sequence, resync flag, and expected outputs.
    int m_level, m_trend, m_zero_run, m_resync;
    int m_dir, m_peak, m_valley, m_turn, m_done, m_count, m_err, m_code;

    function automatic logic [15:0] thermo(int k);
        logic [31:0] t;
        t = (32'd1 << k) - 32'd1;
        return t[15:0];
    endfunction

    task automatic model_reset();
        m_level = 0; m_trend = 0; m_zero_run = 0; m_resync = 0;
        m_dir = 0; m_peak = 0; m_valley = 0; m_turn = 0; m_done = 0;
        m_count = 0; m_err = 0; m_code = 0;
    endtask

    task automatic model_apply(logic [15:0] v);
        int n;
        int delta;
        int prev;
        n = -1;
        for (int k = 0; k <= WIDTH; k++) if (v == thermo(k)) n = k;
        m_dir = 0; m_peak = 0; m_valley = 0; m_done = 0;
        if (n < 0 || n - m_level > 1 || m_level - n > 1) begin
            if (m_err == 0) m_code = (n < 0) ? 1 : 2;
            m_err = 1;
            m_resync = 1; m_trend = 0; m_zero_run = 0;
            if (n >= 0) m_level = n;
            return;
        end
        prev  = m_level;
        delta = n - m_level;
        m_level = n;
        if (m_resync != 0) begin
            if (n == 0) m_resync = 0;
        end else if (m_zero_run > 0) begin
            if (delta == 0) begin
                m_zero_run++;
                if (m_zero_run == QUIET) begin
                    m_done = 1; m_zero_run = 0; m_trend = 0;
                    if (m_count < 255) m_count++;
                end
            end else if (delta == 1) begin
                m_valley = 1; m_turn = 0; m_trend = 1; m_zero_run = 0; m_dir = 1;
            end
        end else if (delta == 1) begin
            if (m_trend == -1) begin m_valley = 1; m_turn = prev; end
            m_trend = 1; m_dir = 1;
        end else if (delta == -1) begin
            if (m_trend == 1) begin m_peak = 1; m_turn = prev; end
            m_trend = -1; m_dir = 2;
            if (n == 0) m_zero_run = 1;
        end
    endtask

    task automatic check(string tag);
        assert (bus.level === LVL_W'(m_level)) else begin
            miscompares++; $error("FAIL %s level got %0d exp %0d", tag, bus.level, m_level); end
        assert (bus.dir === 2'(m_dir)) else begin
            miscompares++; $error("FAIL %s dir got %0d exp %0d", tag, bus.dir, m_dir); end
        assert (bus.peak_pulse === 1'(m_peak)) else begin
            miscompares++; $error("FAIL %s peak got %0d exp %0d", tag, bus.peak_pulse, m_peak); end
        assert (bus.valley_pulse === 1'(m_valley)) else begin
            miscompares++; $error("FAIL %s valley got %0d exp %0d", tag, bus.valley_pulse, m_valley); end
        assert (bus.turn_level === LVL_W'(m_turn)) else begin
            miscompares++; $error("FAIL %s turn_level got %0d exp %0d", tag, bus.turn_level, m_turn); end
        assert (bus.seq_done === 1'(m_done)) else begin
            miscompares++; $error("FAIL %s seq_done got %0d exp %0d", tag, bus.seq_done, m_done); end
        assert (bus.seq_count === SEQ_W'(m_count)) else begin
            miscompares++; $error("FAIL %s seq_count got %0d exp %0d", tag, bus.seq_count, m_count); end
        assert (bus.error === 1'(m_err)) else begin
            miscompares++; $error("FAIL %s error got %0d exp %0d", tag, bus.error, m_err); end
        assert (bus.err_code === 2'(m_code)) else begin
            miscompares++; $error("FAIL %s err_code got %0d exp %0d", tag, bus.err_code, m_code); end
    endtask

    task automatic step(logic [15:0] v, string tag);
        @(negedge clk);
        bus.led_in = v;
        @(posedge clk);
        #1;
        model_apply(v);
        vectors++;
        check(tag);
    endtask

    task automatic sync_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.led_in = '0;
        #1;
        model_reset();
        check("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int r;
        logic [15:0] v;

        rst = 1'b1;
        bus.led_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Full ramp up, ramp down, quiet period ends the sequence.
        for (int i = 1; i <= 16; i++) step(thermo(i), "ramp_up");
        for (int i = 15; i >= 0; i--) step(thermo(i), "ramp_down");
        for (int i = 0; i < 4; i++) step(16'h0000, "quiet");
        assert (bus.seq_count === 8'd1) else begin
            miscompares++; $error("FAIL ramp_seq_count got %0d exp 1", bus.seq_count); end

        // Bounce: peak at 6, valley at 5, rise to 11.
        for (int i = 1; i <= 6; i++) step(thermo(i), "bounce_up");
        step(16'h001F, "bounce_peak");
        for (int i = 6; i <= 11; i++) step(thermo(i), "bounce_rise");

        // Fall to zero, short quiet, restart before expiry.
        for (int i = 10; i >= 0; i--) step(thermo(i), "fall");
        step(16'h0000, "short_quiet");
        step(16'h0000, "short_quiet");
        step(16'h0001, "zero_valley");
        step(16'h0003, "lvl2");

        // Non-thermometer at level 2.
        step(16'h0005, "bad_code");
        assert (bus.level === 5'd2 && bus.err_code === 2'b01) else begin
            miscompares++; $error("FAIL bad_code_hold got lvl %0d code %0d exp lvl 2 code 1", bus.level, bus.err_code); end
        step(16'h0003, "resync");
        step(16'h0001, "resync");
        step(16'h0000, "resync_exit");
        step(16'h0001, "post_resync");
        step(16'h0003, "post_resync");

        // Level jump from 3 to 5, later bad code keeps the first cause.
        sync_reset();
        for (int i = 1; i <= 3; i++) step(thermo(i), "pre_jump");
        step(16'h001F, "jump");
        step(16'h0009, "bad_after_jump");
        assert (bus.err_code === 2'b10) else begin
            miscompares++; $error("FAIL first_cause got %0d exp 2", bus.err_code); end

        // Asynchronous reset between edges mid-rise.
        sync_reset();
        for (int i = 1; i <= 7; i++) step(thermo(i), "pre_async");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_reset");
        @(negedge clk);
        rst = 1'b0;
        bus.led_in = '0;
        step(16'h0001, "after_async");

        // Randomized traffic: mostly legal neighbours, some arbitrary codes.
        for (int i = 0; i < 600; i++) begin
            if (i % 80 == 79) sync_reset();
            r = int'($urandom_range(0, 99));
            if (r < 75) begin
                k = m_level + int'($urandom_range(0, 2)) - 1;
                if (k < 0) k = 0;
                if (k > WIDTH) k = WIDTH;
                v = thermo(k);
            end else if (r < 90) begin
                v = thermo(int'($urandom_range(0, WIDTH)));
            end else begin
                v = 16'($urandom);
            end
            step(v, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
